// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex segment codes (bit0=a..bit6=g, active high),
// the captured-entry layout and the pattern-to-digit decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int ENTRY_W = 6;

  typedef struct packed {
    logic       inval;
    logic       blank;
    logic [3:0] digit;
  } entry_t;

  function automatic entry_t seg7_to_hex(input logic [6:0] seg);
    entry_t e;
    e = '0;
    case (seg)
      SEG_0:     e.digit = 4'h0;
      SEG_1:     e.digit = 4'h1;
      SEG_2:     e.digit = 4'h2;
      SEG_3:     e.digit = 4'h3;
      SEG_4:     e.digit = 4'h4;
      SEG_5:     e.digit = 4'h5;
      SEG_6:     e.digit = 4'h6;
      SEG_7:     e.digit = 4'h7;
      SEG_8:     e.digit = 4'h8;
      SEG_9:     e.digit = 4'h9;
      SEG_A:     e.digit = 4'hA;
      SEG_B:     e.digit = 4'hB;
      SEG_C:     e.digit = 4'hC;
      SEG_D:     e.digit = 4'hD;
      SEG_E:     e.digit = 4'hE;
      SEG_F:     e.digit = 4'hF;
      SEG_BLANK: e.blank = 1'b1;
      default:   e.inval = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/seg7_capture_fifo.sv
// Show-ahead FIFO of captured entries; head is visible as soon as it is written.
// A push into a full FIFO is dropped unless the head is popped in the same cycle.
module seg7_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_rdy_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_dat_o,
  output logic         accept_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty, full, pop;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && pop_rdy_i;

  always_comb begin
    accept_o = push_i && (!full || pop);
    drop_o   = push_i && full && !pop;
    wr_d     = accept_o ? wr_q + (AW+1)'(1) : wr_q;
    rd_d     = pop ? rd_q + (AW+1)'(1) : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_o) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_vld_o = !empty;
  assign head_dat_o = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/seg7_capture.sv
// Captures stable 7-segment patterns, decodes them to hex and queues each new digit.
// Latency seg_in->out_valid is 2 + STABLE_CYCLES + 1 cycles; full FIFO drops and flags ovf.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             clear_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_blank,
  output logic             out_inval,
  output logic             ovf,
  output logic [CNT_W-1:0] commits
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]       sync1_q, s2_q, s3_q, last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             commit_q, commit_d;
  entry_t           entry_q, entry_d, head;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] commits_q, commits_d;
  logic             accept, drop;

  always_comb begin
    if (s2_q != s3_q)        cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CW'(1);
    // Commit only on the edge into stability, and only for a pattern not already queued.
    commit_d  = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX) && (s2_q != last_q);
    last_d    = commit_d ? s2_q : last_q;
    entry_d   = commit_d ? seg7_to_hex(s2_q) : entry_q;
    ovf_d     = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    commits_d = accept ? commits_q + CNT_W'(1) : commits_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      cnt_q     <= '0;
      last_q    <= SEG_BLANK;
      commit_q  <= 1'b0;
      entry_q   <= '0;
      ovf_q     <= 1'b0;
      commits_q <= '0;
    end else begin
      sync1_q   <= seg_in;
      s2_q      <= sync1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      commit_q  <= commit_d;
      entry_q   <= entry_d;
      ovf_q     <= ovf_d;
      commits_q <= commits_d;
    end
  end

  seg7_capture_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (commit_q),
    .push_dat_i (entry_q),
    .pop_rdy_i  (out_ready),
    .head_vld_o (out_valid),
    .head_dat_o (head),
    .accept_o   (accept),
    .drop_o     (drop)
  );

  assign out_digit = head.digit;
  assign out_blank = head.blank;
  assign out_inval = head.inval;
  assign ovf       = ovf_q;
  assign commits   = commits_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench: a run-length reference model queues expected entries,
// a negedge monitor compares each accepted FIFO head against the queue.
module tb_seg7_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       clear_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_inval;
  logic       ovf;
  logic [7:0] commits;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_blank (out_blank),
    .out_inval (out_inval),
    .ovf       (ovf),
    .commits   (commits)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [5:0] exp_q [$];
  logic [5:0] mon_e;

  // Reference model state: current input run and last committed pattern.
  logic [7:0] m_cur = 8'hFF;
  int         m_run = 0;
  logic [6:0] m_last = 7'h00;
  int         m_commits = 0;
  bit         m_drop = 1'b0;
  bit         rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (HEX[i] == p) return {2'b00, 4'(i)};
    if (p == 7'h00) return 6'b010000;
    return 6'b100000;
  endfunction

  task automatic model_step(input logic [6:0] p, input int n);
    if ({1'b0, p} != m_cur) begin
      m_cur = {1'b0, p};
      m_run = 0;
    end
    if (m_run < STABLE && m_run + n >= STABLE && p != m_last) begin
      m_last = p;
      if (!m_drop) begin
        exp_q.push_back(ref_decode(p));
        m_commits++;
      end
    end
    m_run += n;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    model_step(p, n);
    seg_in = p;
    repeat (n) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 7) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) hold(m_cur[6:0], 1);
    hold(m_cur[6:0], 2);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_valid_low"}, out_valid, 0);
    chk({nm, "_commits"}, commits, 32'(m_commits % 256));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_entry: got %0h expected none", {out_inval, out_blank, out_digit});
      end else begin
        mon_e = exp_q.pop_front();
        chk("entry", {out_inval, out_blank, out_digit}, mon_e);
      end
    end
  end

  initial begin
    rst_n = 1'b1; seg_in = 7'h7F; clear_ovf = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_digit", out_digit, 0);
    chk("rst_blank", out_blank, 0);
    chk("rst_inval", out_inval, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_commits", commits, 0);
    rst_n = 1'b1;

    hold(7'h7F, 10);
    chk("t1_commits", commits, 1);
    chk("t1_valid", out_valid, 1);
    drain("t1");

    hold(7'h3F, 8);
    hold(7'h06, 2);
    hold(7'h3F, 8);
    drain("t2");

    for (int i = 0; i < 16; i++) hold(HEX[i], 6);
    hold(7'h00, 6);
    hold(7'h01, 6);
    drain("t3");

    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) hold(HEX[i], 8);
    m_drop = 1'b1;
    hold(HEX[5], 8);
    m_drop = 1'b0;
    hold(HEX[5], 4);
    chk("t4_ovf_set", ovf, 1);
    chk("t4_commits", commits, 32'(m_commits % 256));
    chk("t4_valid", out_valid, 1);
    clear_ovf = 1'b1;
    hold(HEX[5], 1);
    clear_ovf = 1'b0;
    chk("t4_ovf_clr", ovf, 0);
    drain("t4");

    out_ready = 1'b0;
    for (int i = 6; i <= 9; i++) hold(HEX[i], 8);
    model_step(HEX[10], 7);
    seg_in = HEX[10];
    repeat (6) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    hold(HEX[10], 3);
    chk("t5_no_ovf", ovf, 0);
    chk("t5_commits", commits, 32'(m_commits % 256));
    drain("t5");

    out_ready = 1'b0;
    for (int i = 11; i <= 13; i++) hold(HEX[i], 8);
    chk("t6_valid_before", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", out_valid, 0);
    chk("t6_commits_async", commits, 0);
    rst_n = 1'b1;
    exp_q.delete();
    m_last = 7'h00; m_cur = 8'hFF; m_run = 0; m_commits = 0;
    hold(HEX[13], 10);
    drain("t6");

    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int sel;
      logic [6:0] p;
      int n;
      sel = $urandom_range(0, 9);
      if (sel < 7)       p = HEX[$urandom_range(0, 15)];
      else if (sel == 7) p = 7'h00;
      else               p = 7'($urandom_range(0, 127));
      n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 10);
      hold(p, n);
    end
    rand_rdy = 1'b0;
    hold(m_cur[6:0], 12);
    drain("rand");
    chk("rand_no_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
